uart_alu_sequencer: RTL

Controller that sequences the UART/ALU datapath in both directions. It pulls a 3-byte command frame (opcode, A, B) from the RX FIFO and loads the ALU operand registers. It then captures the ALU result and pushes it into the TX FIFO for transmission back to the host. An inter-byte timeout discards partial frames so that host and FPGA resynchronise after a dropped byte.

---
 rtl/uart_alu_pkg.sv | 32 +++
 rtl/seq_timeout_counter.sv | 35 +++
 rtl/uart_alu_sequencer.sv | 122 ++++++++++++
 3 files changed

// File: rtl/uart_alu_pkg.sv
// Shared definitions for the UART/ALU sequencer: FSM state codes, the ALU
// opcode map, and small helpers used by the sequencer.
package uart_alu_pkg;

    // Sequencer state encoding
    localparam logic [2:0] S_OP   = 3'd0;
    localparam logic [2:0] S_A    = 3'd1;
    localparam logic [2:0] S_B    = 3'd2;
    localparam logic [2:0] S_EXEC = 3'd3;
    localparam logic [2:0] S_SEND = 3'd4;

    // Opcode map shared with the ALU
    localparam logic [5:0] ADD = 6'b100000;
    localparam logic [5:0] SUB = 6'b100010;
    localparam logic [5:0] AND = 6'b100100;
    localparam logic [5:0] OR  = 6'b100101;
    localparam logic [5:0] XOR = 6'b100110;
    localparam logic [5:0] SRA = 6'b000011;
    localparam logic [5:0] SRL = 6'b000010;
    localparam logic [5:0] NOR = 6'b100111;

    // True in the states that pull a frame byte from the RX FIFO
    function automatic logic is_fetch(input logic [2:0] s);
        return (s == S_OP) || (s == S_A) || (s == S_B);
    endfunction

    // True in the states guarded by the inter-byte timeout
    function automatic logic is_mid_frame(input logic [2:0] s);
        return (s == S_A) || (s == S_B);
    endfunction

endpackage

// File: rtl/seq_timeout_counter.sv
// Up-counter with clear, load and enable; flags the terminal count
// (TERMINAL-1) so the owner can act on the same cycle. The counter parks at
// the terminal value instead of wrapping, so a late clear is harmless.
module seq_timeout_counter #(
    parameter int NB       = 20,
    parameter int TERMINAL = 1_000_000
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          clear,
    input  logic          load,
    input  logic [NB-1:0] load_val,
    input  logic          enable,
    output logic          tc
);

    localparam logic [NB-1:0] TC_VAL = NB'(TERMINAL - 1);

    logic [NB-1:0] count;

    // Count register: clear beats load beats increment
    always_ff @(posedge clock) begin
        if (reset)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (enable && (count != TC_VAL))
            count <= count + 1'b1;
    end

    assign tc = (count == TC_VAL);

endmodule

// File: rtl/uart_alu_sequencer.sv
// Pulls 3-byte command frames (opcode, A, B) from the RX FIFO into the ALU
// operand registers, captures the ALU result and pushes it to the TX FIFO.
// A stalled partial frame is dropped after TIMEOUT_CYC idle cycles so the
// host can resynchronise.
module uart_alu_sequencer
    import uart_alu_pkg::*;
#(
    parameter int DBIT        = 8,
    parameter int NB_OP       = 6,
    parameter int TIMEOUT_CYC = 1_000_000,
    parameter int NB_TO       = 20
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_rx_empty,
    input  logic [DBIT-1:0]  i_rx_data,
    output logic             o_rx_rd,
    input  logic             i_tx_full,
    output logic             o_tx_wr,
    output logic [DBIT-1:0]  o_tx_data,
    output logic [NB_OP-1:0] o_alu_op,
    output logic [DBIT-1:0]  o_alu_a,
    output logic [DBIT-1:0]  o_alu_b,
    input  logic [DBIT-1:0]  i_alu_result,
    output logic             o_busy,
    output logic             o_timeout,
    output logic [7:0]       o_frame_cnt
);

    logic [2:0] state;
    logic [2:0] state_nxt;
    logic       to_tc;
    logic       to_clear;

    // Inter-byte timer only runs between bytes of a frame; any pop, a fired
    // timeout or leaving the frame states restarts it from zero.
    assign to_clear = !is_mid_frame(state) || o_rx_rd || o_timeout;

    seq_timeout_counter #(
        .NB       (NB_TO),
        .TERMINAL (TIMEOUT_CYC)
    ) u_timeout (
        .clock    (clock),
        .reset    (reset),
        .clear    (to_clear),
        .load     (1'b0),
        .load_val ('0),
        .enable   (is_mid_frame(state)),
        .tc       (to_tc)
    );

    // State register
    always_ff @(posedge clock) begin
        if (reset)
            state <= S_OP;
        else
            state <= state_nxt;
    end

    // Next-state logic; a pop at terminal count wins over the timeout
    always_comb begin
        state_nxt = state;
        case (state)
            S_OP:    if (o_rx_rd) state_nxt = S_A;
            S_A:     if (o_rx_rd) state_nxt = S_B;
                     else if (o_timeout) state_nxt = S_OP;
            S_B:     if (o_rx_rd) state_nxt = S_EXEC;
                     else if (o_timeout) state_nxt = S_OP;
            S_EXEC:  state_nxt = S_SEND;
            S_SEND:  if (o_tx_wr) state_nxt = S_OP;
            default: state_nxt = S_OP;
        endcase
    end

    // FIFO strobes and status; strobes are masked while reset is held so a
    // reset cycle never moves data
    always_comb begin
        o_rx_rd   = 1'b0;
        o_tx_wr   = 1'b0;
        o_busy    = (state != S_OP);
        o_timeout = 1'b0;
        if (!reset) begin
            if (is_fetch(state))
                o_rx_rd = !i_rx_empty;
            if (state == S_SEND)
                o_tx_wr = !i_tx_full;
            o_timeout = is_mid_frame(state) && to_tc && i_rx_empty;
        end
    end

    // Operand/opcode capture, result capture and frame counter. Operands
    // keep their value until the matching byte of a later frame arrives.
    always_ff @(posedge clock) begin
        if (reset) begin
            o_alu_op    <= '0;
            o_alu_a     <= '0;
            o_alu_b     <= '0;
            o_tx_data   <= '0;
            o_frame_cnt <= '0;
        end else begin
            if (o_rx_rd) begin
                case (state)
                    S_OP:    o_alu_op <= i_rx_data[NB_OP-1:0];
                    S_A:     o_alu_a  <= i_rx_data;
                    S_B:     o_alu_b  <= i_rx_data;
                    default: ;
                endcase
            end
            if (state == S_EXEC)
                o_tx_data <= i_alu_result;
            if (o_tx_wr)
                o_frame_cnt <= o_frame_cnt + 8'd1;
        end
    end

    // FIFO protocol guards
    a_no_pop_when_empty: assert property (@(posedge clock) disable iff (reset)
        !(o_rx_rd && i_rx_empty));
    a_no_push_when_full: assert property (@(posedge clock) disable iff (reset)
        !(o_tx_wr && i_tx_full));

endmodule
